// File: rtl/i2c_mock_slave.sv
// I2C target (slave) responder: START/STOP detection, 7-bit address match, write
// bytes out on rx_data, read bytes served from tx_data. Open-drain SDA, no stretching.
module i2c_mock_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       scl,
  inout  logic       sda,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       nack_seen
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t      state;
  logic        sda_oe;
  logic        scl_q, sda_q;
  logic [2:0]  cnt;
  logic [7:0]  shreg;
  logic        is_read;
  logic        got;      // a rise has been seen since the last handled fall
  logic        sda_in;
  logic        rise, fall, start, stop;

  assign sda    = sda_oe ? 1'b0 : 1'bz;
  assign sda_in = sda;

  assign rise  =  scl & ~scl_q;
  assign fall  = ~scl &  scl_q;
  assign start =  scl &  scl_q &  sda_q & ~sda_in;
  assign stop  =  scl &  scl_q & ~sda_q &  sda_in;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      busy      <= 1'b0;
      nack_seen <= 1'b0;
      cnt       <= 3'd7;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      shreg     <= '0;
      is_read   <= 1'b0;
      got       <= 1'b0;
    end else begin
      scl_q    <= scl;
      sda_q    <= sda_in;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      if (start) begin
        state     <= ADDR;
        cnt       <= 3'd7;
        busy      <= 1'b1;
        nack_seen <= 1'b0;
        sda_oe    <= 1'b0;
        got       <= 1'b0;
      end else if (stop) begin
        state  <= IDLE;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
        got    <= 1'b0;
      end else begin
        case (state)
          IDLE: sda_oe <= 1'b0;
          ADDR, WR_DATA: begin
            if (rise) begin
              shreg <= {shreg[6:0], sda_in};
              got   <= 1'b1;
            end else if (fall && got) begin
              got <= 1'b0;
              if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
              end else if (state == WR_DATA) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                sda_oe   <= 1'b1;
                state    <= WR_ACK;
              end else if (shreg[7:1] == SLAVE_ADDR) begin
                is_read <= shreg[0];
                sda_oe  <= 1'b1;
                state   <= ADDR_ACK;
                if (shreg[0]) begin
                  tx_load <= 1'b1;
                  shreg   <= tx_data;
                end
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (fall) begin
              cnt <= 3'd7;
              got <= 1'b0;
              if (is_read) begin
                sda_oe <= ~shreg[7];
                state  <= RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= WR_DATA;
              end
            end
          end
          WR_ACK: begin
            if (fall) begin
              sda_oe <= 1'b0;
              cnt    <= 3'd7;
              got    <= 1'b0;
              state  <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (rise) begin
              got <= 1'b1;
            end else if (fall && got) begin
              got <= 1'b0;
              if (cnt != 3'd0) begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
                cnt    <= cnt - 3'd1;
              end else begin
                sda_oe <= 1'b0;
                state  <= RD_ACK;
              end
            end
          end
          RD_ACK: begin
            if (rise) begin
              if (sda_in) begin
                nack_seen <= 1'b1;
                state     <= WAIT_STOP;
              end else begin
                got <= 1'b1;
              end
            end else if (fall && got) begin
              got     <= 1'b0;
              tx_load <= 1'b1;
              shreg   <= tx_data;
              sda_oe  <= ~tx_data[7];
              cnt     <= 3'd7;
              state   <= RD_DATA;
            end
          end
          WAIT_STOP: sda_oe <= 1'b0;
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
